// File: rtl/l1a_ram_rd_arbiter.sv
// rtl/l1a_ram_rd_arbiter.sv - round-robin arbiter for the single read port of ram_L1A
//
// Purpose: shares the one read port of the 64-entry L1A RAM between N_REQ
// requesters (L1A checker, readout builder, slow-control reader). One grant
// per cycle at most; every issued read is tracked through a RD_LAT-deep
// pipeline so the returned word is steered back to the requester that asked.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   arb_en       allows new grants when high; in-flight reads always complete
//   req_valid    per-requester request, held with a stable address until granted
//   req_addr     packed per-requester addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready    one-cycle grant pulse, one-hot or zero
//   ram_rd_req   read strobe to ram_L1A
//   ram_rd_addr  read address to ram_L1A, holds when no read is issued
//   ram_rd_data  RAM data, valid RD_LAT cycles after the ram_rd_req cycle
//   rsp_valid    one-cycle response pulse to the issuing requester, one-hot or zero
//   rsp_data     returned word, valid while any rsp_valid bit is high, else held
module l1a_ram_rd_arbiter #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    arb_en,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    ram_rd_req,
   output logic [ADDR_W-1:0]       ram_rd_addr,
   input  logic [DATA_W-1:0]       ram_rd_data,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data
);

   localparam int ID_W = $clog2(N_REQ);

   // Unpacked view of the per-requester addresses
   logic [ADDR_W-1:0] addr_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_addr
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
   end

   // Arbitration state
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   gnt_id;

   // Winner search
   logic [N_REQ-1:0]  eligible;
   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   next_ptr;
   logic [ID_W:0]     scan_sum;
   logic [ID_W-1:0]   scan_idx;

   // Response pipeline: one (valid, id) pair per stage
   logic [RD_LAT-1:0] pipe_valid;
   logic [ID_W-1:0]   pipe_id [RD_LAT];

   // A requester that is being granted this cycle is masked, so a held
   // req_valid is only seen as a fresh request from the following cycle.
   always_comb begin
      eligible  = req_valid & ~req_ready;
      win_found = 1'b0;
      win_id    = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         // Position k of the scan, starting at rr_ptr and wrapping at N_REQ
         scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_sum >= (ID_W+1)'(N_REQ)) begin
            scan_sum = scan_sum - (ID_W+1)'(N_REQ);
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!win_found && eligible[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
      if (win_id == ID_W'(N_REQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = win_id + ID_W'(1);
      end
   end

   // Grant register: grant pulse, RAM strobe and address all appear in the
   // cycle after the request was sampled. rr_ptr only moves on a grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_ready   <= '0;
         ram_rd_req  <= 1'b0;
         ram_rd_addr <= '0;
         gnt_id      <= '0;
         rr_ptr      <= '0;
      end else begin
         req_ready  <= '0;
         ram_rd_req <= 1'b0;
         if (arb_en && win_found) begin
            req_ready   <= N_REQ'(1) << win_id;
            ram_rd_req  <= 1'b1;
            ram_rd_addr <= addr_arr[win_id];
            gnt_id      <= win_id;
            rr_ptr      <= next_ptr;
         end
      end
   end

   // The strobe enters stage 0 at the end of its own cycle, so the pair leaves
   // the last stage on the edge that closes the cycle in which ram_rd_data is
   // valid for it. Reset empties the pipeline and drops in-flight reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_valid <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            pipe_id[s] <= '0;
         end
      end else begin
         pipe_valid[0] <= ram_rd_req;
         pipe_id[0]    <= gnt_id;
         for (int s = 1; s < RD_LAT; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_id[s]    <= pipe_id[s-1];
         end
      end
   end

   // Response register: in-order, at most one per cycle, data held between pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= '0;
         if (pipe_valid[RD_LAT-1]) begin
            rsp_valid <= N_REQ'(1) << pipe_id[RD_LAT-1];
            rsp_data  <= ram_rd_data;
         end
      end
   end

endmodule

// File: doc/l1a_ram_rd_arbiter.md
# l1a_ram_rd_arbiter

Round-robin arbiter that shares the single read port of the 64-entry L1A RAM (`ram_L1A`) between up to `N_REQ` requesters, such as the L1A checker, the readout builder and the debug/slow-control reader. It accepts one read request per cycle and drives the RAM read request and address. It tracks every in-flight read through a fixed-latency pipeline and returns the RAM data to the requester that issued the read. The block sits between the requesters and `ram_L1A` in the LV2 layer-2 datapath.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 6: RAM address width (64 entries).
- `DATA_W`, 16: RAM data width.
- `RD_LAT`, 2: RAM read latency in cycles (1..4).

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `arb_en` input 1: when high, new grants are allowed; when low, no new grants are issued.
- `req_valid` input N_REQ: per-requester read request; held high with a stable address until granted.
- `req_addr` input N_REQ*ADDR_W: per-requester address; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_ready` output N_REQ: one-cycle grant pulse; one-hot or zero.
- `ram_rd_req` output 1: read strobe to `ram_L1A`.
- `ram_rd_addr` output ADDR_W: read address to `ram_L1A`.
- `ram_rd_data` input DATA_W: RAM data, valid exactly `RD_LAT` cycles after the `ram_rd_req` cycle.
- `rsp_valid` output N_REQ: one-cycle response pulse; one-hot or zero.
- `rsp_data` output DATA_W: returned data, valid while any `rsp_valid` bit is high.

## Operation
- **Reset values:** all outputs are 0, `rr_ptr` is 0 and the response pipeline is empty. Reset acts immediately and asynchronously.
- **Arbitration (edge at end of cycle T):**
  - Eligible requesters satisfy `req_valid[i] & ~req_ready[i]`. A requester is masked during the cycle its grant pulse is high.
  - Scan from `rr_ptr` upward with wrap-around; the first eligible requester wins (w).
  - If there is no winner, or `arb_en` = 0, the registered outputs in T+1 are `req_ready` = 0 and `ram_rd_req` = 0, and `rr_ptr` is unchanged.
  - On a winner, in T+1: `req_ready[w]` = 1, `ram_rd_req` = 1, `ram_rd_addr` = `req_addr[w]` as sampled at T, and `rr_ptr` = (w+1) mod N_REQ.
- **Requester rules:**
  - A requester may change its address or drop `req_valid` only in the cycle after `req_ready` is seen.
  - Keeping `req_valid` high through the grant cycle means a new request with the address currently presented.
- **`ram_rd_addr`:** holds its last value when `ram_rd_req` = 0.
- **Response pipeline:**
  - A shift register of depth `RD_LAT` carries a (valid, id) pair for each read issued.
  - On the edge where a pair exits the pipeline, the block registers `rsp_data` from `ram_rd_data` and pulses `rsp_valid[id]`.
  - `rsp_data` holds its value otherwise.
  - Responses are returned strictly in grant order; at most one response per cycle.
- **`arb_en` low:** in-flight reads still complete and respond. Granting resumes from the saved `rr_ptr` on the first sampled cycle with `arb_en` = 1.
- **Address range:** every address from 0 to 63 is legal; there is no range check and no wrap logic on addresses.

## Timing
- Request-to-grant latency: `req_valid` sampled at edge T gives `req_ready`, `ram_rd_req` and `ram_rd_addr` in cycle T+1.
- Grant-to-response latency: `rsp_valid` rises in cycle T+1+RD_LAT+1, i.e. T+4 for `RD_LAT` = 2.
- Throughput: one read per cycle across requesters. A single continuously-valid requester is granted every other cycle because of the grant mask.
- Simultaneous events:
  - A grant and a response to the same or different requesters in the same cycle are independent.
  - `arb_en` falling at edge T suppresses any grant in T+1.
- Reset mid-operation: in-flight reads are discarded, no `rsp_valid` is produced for them, and `ram_rd_req` drops to 0 immediately.

## Test plan
- **Reset values:** assert `reset` asynchronously, between clock edges, while `req_valid` = 3'b111. Required: all outputs read 0 immediately; after release the first grant goes to requester 0.
- **Single read:** requester 1 presents address 0x05; the RAM model returns 0x1234 at `RD_LAT` = 2. Required:
  - `req_ready` = 3'b010, `ram_rd_req` = 1 and `ram_rd_addr` = 0x05 at T+1.
  - `rsp_valid` = 3'b010 with `rsp_data` = 0x1234 at T+4.
- **Full contention:** all three requesters continuously valid. Required:
  - Grants cycle 0,1,2,0,1,2 on consecutive cycles.
  - Responses arrive in the same order, 3 cycles after each grant, with the data matching each address.
- **Single hog:** only requester 2 is continuously valid, with addresses 63, 0, 1. Required:
  - Grants occur every other cycle.
  - `ram_rd_addr` sequence is 0x3F, 0x00, 0x01, and the responses match.
- **Enable gating:** drop `arb_en` for 5 cycles right after a grant to requester 0, with requesters 0 and 1 pending. Required:
  - The in-flight response is still delivered and no grant occurs during the gap.
  - The first grant after re-enable goes to requester 1.
- **Reset during in-flight reads:** pulse `reset` one cycle after two grants. Required: no `rsp_valid` follows and the RAM model sees no further `ram_rd_req`.
